// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM encoding and sizing helpers for seq_multiplier
//
// Purpose : Holds the multiplier FSM state type and the iteration-counter
//           width function so the top and any future companions agree on them.
// Ports   : none (package)
// Macros  : none

package mult_pkg;

   // FSM encodings are fixed so that state can be probed and decoded
   // consistently by anything outside the block.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Counter must be able to hold the values 0..n, hence clog2(n+1).
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/addsub_n.sv
// rtl/addsub_n.sv - N+1-bit adder/subtractor used by the shift-add datapath
//
// Purpose : sum = x + y when sub=0, sum = x - y when sub=1 (two's complement,
//           implemented as x + ~y + 1). cout is the carry out of bit N.
// Ports   : sum  [N:0] out - result, same width as the operands
//           cout       out - carry out of the MSB
//           x    [N:0] in  - first operand
//           y    [N:0] in  - second operand
//           sub        in  - 1 selects subtraction
// Macros  : none

module addsub_n #(
   parameter int N = 4
) (
   output logic [N:0] sum,
   output logic       cout,
   input  logic [N:0] x,
   input  logic [N:0] y,
   input  logic       sub
);

   logic [N:0]   y_eff;
   logic [N+1:0] total;

   // Subtraction reuses the adder: invert y and inject the +1 as carry in.
   assign y_eff = sub ? ~y : y;
   assign total = {1'b0, x} + {1'b0, y_eff} + {{(N+1){1'b0}}, sub};

   assign sum  = total[N:0];
   assign cout = total[N+1];

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 sequential shift-add multiplier, N cycles per product
//
// Purpose : Multiplies two N-bit operands one multiplier bit per clock, LSB
//           first, and presents the exact 2N-bit product on p with a one-cycle
//           done pulse. A new start is accepted in IDLE or in the DONE cycle,
//           so products can be streamed back to back every N+1 cycles.
// Ports   : clk          in  - clock, all state on its rising edge
//           reset        in  - synchronous, active-high; overrides start
//           start        in  - begin a multiply (ignored while busy)
//           a     [N-1:0] in  - multiplier, captured when start is accepted
//           b     [N-1:0] in  - multiplicand, captured when start is accepted
//           p   [2N-1:0] out - product register, only written on entry to DONE
//           busy         out - high exactly while the FSM is in RUN
//           done         out - high for the single DONE cycle
// Macros  : MULT_SIGNED_EN - when defined, a, b and p are two's complement;
//           the final step subtracts and the accumulator shift sign-extends.

module seq_multiplier
   import mult_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p,
   output logic           busy,
   output logic           done
);

   localparam int            CW        = cnt_width(N);
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

`ifdef MULT_SIGNED_EN
   localparam logic SIGNED_EN = 1'b1;
`else
   localparam logic SIGNED_EN = 1'b0;
`endif

   // Datapath layout: {hi_q, lo_q} is the running partial product shifted
   // right once per step. lo_q starts out holding the multiplier, so lo_q[0]
   // is always the multiplier bit for the current step, and product bits
   // shift into lo_q from the top as multiplier bits fall out of the bottom.
   state_e         state_q, state_d;
   logic [N-1:0]   b_q,     b_d;
   logic [N-1:0]   hi_q,    hi_d;
   logic [N-1:0]   lo_q,    lo_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [2*N-1:0] p_q,     p_d;

   logic           last_step;
   logic           add_en;
   logic [N:0]     as_x;
   logic [N:0]     as_y;
   logic [N:0]     as_sum;
   logic           as_sub;
   logic           as_cout_unused;

   assign last_step = (cnt_q == LAST_STEP);
   assign add_en    = lo_q[0];

   // Operands are widened to N+1 bits so the step result never overflows:
   // zero extension for unsigned, sign extension for two's complement.
   assign as_x   = {SIGNED_EN & hi_q[N-1], hi_q};
   assign as_y   = add_en ? {SIGNED_EN & b_q[N-1], b_q} : '0;
   // In two's complement the multiplier MSB carries weight -2^(N-1), so the
   // final step subtracts the multiplicand instead of adding it.
   assign as_sub = SIGNED_EN & last_step & add_en;

   addsub_n #(
      .N (N)
   ) u_addsub (
      .sum  (as_sum),
      .cout (as_cout_unused),
      .x    (as_x),
      .y    (as_y),
      .sub  (as_sub)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               lo_d    = a;
               b_d     = b;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            busy  = 1'b1;
            // Shift right by one: the N+1-bit step result becomes the new
            // high half (its top bit provides the carry or sign fill) and
            // its LSB drops into the low half.
            hi_d  = as_sum[N:1];
            lo_d  = {as_sum[0], lo_q[N-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
               // p is loaded straight from the final step so partial sums
               // never reach the output.
               p_d     = {as_sum, lo_q[N-1:1]};
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign p = p_q;

endmodule
